// File: rtl/lms_fifo_pkg.sv
// Shared definitions for the LMS datapath FIFO: read-mode encodings and width helpers.
package lms_fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Level counter needs one extra bit to represent a completely full FIFO
    function automatic int unsigned level_width(input int unsigned depth_width);
        return depth_width + 1;
    endfunction

endpackage

// File: rtl/lms_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module lms_fifo_ram
    import lms_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Array write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; holds its value when no read is requested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/lms_sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read mode, flush and
// sticky overflow/underflow flags.
module lms_sync_fifo
    import lms_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned DEPTH_WIDTH      = 10,
    parameter int unsigned FWFT             = 0,
    parameter int unsigned ALMOST_FULL_NUM  = 1020,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   water_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned LEVEL_WIDTH = level_width(DEPTH_WIDTH);
    localparam int unsigned DEPTH       = 1 << DEPTH_WIDTH;
    localparam bit          IS_FWFT     = (FWFT == FIFO_MODE_FWFT);

    localparam logic [LEVEL_WIDTH-1:0] LVL_DEPTH = LEVEL_WIDTH'(DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] LVL_AF    = LEVEL_WIDTH'(ALMOST_FULL_NUM);
    localparam logic [LEVEL_WIDTH-1:0] LVL_AE    = LEVEL_WIDTH'(ALMOST_EMPTY_NUM);
    localparam logic [LEVEL_WIDTH-1:0] LVL_ZERO  = '0;
    localparam logic [LEVEL_WIDTH-1:0] LVL_ONE   = LEVEL_WIDTH'(1);

    logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   full_q, afull_q, empty_q, aempty_q;
    logic                   rd_valid_q, rd_valid_d;
    logic                   ovf_q, udf_q;
    logic [DATA_WIDTH-1:0]  head_q;
    logic                   head_sel_ram_q;

    logic                   do_wr, do_rd;
    logic                   head_load_wr, mem_we, mem_re;
    logic [DATA_WIDTH-1:0]  ram_rd_data;

    // Accept decisions use only pre-edge flags; flush blocks both sides
    always_comb begin
        do_wr = wr_en & ~full_q & ~flush;
        do_rd = rd_en & ~empty_q & ~flush;
        if (IS_FWFT) begin
            // Head register is loaded straight from wr_data when it is (or is about to be) empty
            head_load_wr = do_wr & ((level_q == LVL_ZERO) | ((level_q == LVL_ONE) & do_rd));
            mem_we       = do_wr & ~head_load_wr;
            mem_re       = do_rd & (level_q > LVL_ONE);
        end else begin
            head_load_wr = 1'b0;
            mem_we       = do_wr;
            mem_re       = do_rd;
        end
    end

    // Next level and next rd_valid
    always_comb begin
        level_d = level_q;
        unique case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (flush) begin
            level_d = '0;
        end
        rd_valid_d = IS_FWFT ? (level_d != LVL_ZERO) : do_rd;
    end

    // Pointers, level, status flags and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            empty_q    <= 1'b1;
            aempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                ovf_q    <= 1'b0;
                udf_q    <= 1'b0;
            end else begin
                if (mem_we) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (mem_re) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                if (wr_en && full_q) begin
                    ovf_q <= 1'b1;
                end
                if (rd_en && empty_q) begin
                    udf_q <= 1'b1;
                end
            end
            level_q    <= level_d;
            full_q     <= (level_d == LVL_DEPTH);
            afull_q    <= (level_d >= LVL_AF);
            empty_q    <= (level_d == LVL_ZERO);
            aempty_q   <= (level_d <= LVL_AE);
            rd_valid_q <= rd_valid_d;
        end
    end

    // FWFT output stage: head word comes either from wr_data or the RAM read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= '0;
            head_sel_ram_q <= 1'b0;
        end else if (head_load_wr) begin
            head_q         <= wr_data;
            head_sel_ram_q <= 1'b0;
        end else if (mem_re && IS_FWFT) begin
            head_sel_ram_q <= 1'b1;
        end
    end

    lms_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (mem_re),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    assign rd_data      = (IS_FWFT && !head_sel_ram_q) ? head_q : ram_rd_data;
    assign rd_valid     = rd_valid_q;
    assign rd_empty     = empty_q;
    assign almost_empty = aempty_q;
    assign wr_full      = full_q;
    assign almost_full  = afull_q;
    assign water_level  = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_lms_sync_fifo.sv
// Directed bench for lms_sync_fifo: one standard-mode and one FWFT instance, depth 8.
module tb_lms_sync_fifo;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          s_flush = 0, s_wr_en = 0, s_rd_en = 0;
    logic [DW-1:0] s_wr_data = '0;
    logic          s_full, s_afull, s_valid, s_empty, s_aempty, s_ovf, s_udf;
    logic [DW-1:0] s_rd_data;
    logic [AW:0]   s_level;

    logic          f_flush = 0, f_wr_en = 0, f_rd_en = 0;
    logic [DW-1:0] f_wr_data = '0;
    logic          f_full, f_afull, f_valid, f_empty, f_aempty, f_ovf, f_udf;
    logic [DW-1:0] f_rd_data;
    logic [AW:0]   f_level;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] nxt_wr;

    always #5 clk = ~clk;

    lms_sync_fifo #(
        .DATA_WIDTH (DW), .DEPTH_WIDTH (AW), .FWFT (0),
        .ALMOST_FULL_NUM (6), .ALMOST_EMPTY_NUM (2)
    ) u_std (
        .clk (clk), .rst_n (rst_n), .flush (s_flush),
        .wr_en (s_wr_en), .wr_data (s_wr_data), .wr_full (s_full), .almost_full (s_afull),
        .rd_en (s_rd_en), .rd_data (s_rd_data), .rd_valid (s_valid), .rd_empty (s_empty),
        .almost_empty (s_aempty), .water_level (s_level), .overflow (s_ovf), .underflow (s_udf)
    );

    lms_sync_fifo #(
        .DATA_WIDTH (DW), .DEPTH_WIDTH (AW), .FWFT (1),
        .ALMOST_FULL_NUM (6), .ALMOST_EMPTY_NUM (2)
    ) u_fwft (
        .clk (clk), .rst_n (rst_n), .flush (f_flush),
        .wr_en (f_wr_en), .wr_data (f_wr_data), .wr_full (f_full), .almost_full (f_afull),
        .rd_en (f_rd_en), .rd_data (f_rd_data), .rd_valid (f_valid), .rd_empty (f_empty),
        .almost_empty (f_aempty), .water_level (f_level), .overflow (f_ovf), .underflow (f_udf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        #1;
        // Reset values
        check("std_rst_level", 32'(s_level), 0);
        check("std_rst_empty", 32'(s_empty), 1);
        check("std_rst_aempty", 32'(s_aempty), 1);
        check("std_rst_full", 32'(s_full), 0);
        check("std_rst_afull", 32'(s_afull), 0);
        check("std_rst_data", 32'(s_rd_data), 0);
        check("std_rst_valid", 32'(s_valid), 0);
        check("std_rst_ovf", 32'(s_ovf), 0);
        check("std_rst_udf", 32'(s_udf), 0);
        check("fwft_rst_empty", 32'(f_empty), 1);
        check("fwft_rst_valid", 32'(f_valid), 0);
        check("fwft_rst_data", 32'(f_rd_data), 0);
        tick();

        // Standard: write 0x11..0x14, read back with latency 1
        for (int i = 0; i < 4; i++) begin
            s_wr_en = 1; s_wr_data = 8'h11 + 8'(i);
            tick();
        end
        s_wr_en = 0;
        check("std_wr4_level", 32'(s_level), 4);
        check("std_wr4_empty", 32'(s_empty), 0);
        check("std_wr4_aempty", 32'(s_aempty), 0);
        for (int i = 0; i < 4; i++) begin
            s_rd_en = 1;
            tick();
            check("std_rd_valid", 32'(s_valid), 1);
            check("std_rd_data", 32'(s_rd_data), 32'h11 + i);
            check("std_rd_level", 32'(s_level), 3 - i);
        end
        s_rd_en = 0;
        tick();
        check("std_rd_valid_pulse", 32'(s_valid), 0);
        check("std_rd_empty_end", 32'(s_empty), 1);
        check("std_rd_data_hold", 32'(s_rd_data), 32'h14);

        // FWFT: single word falls through without rd_en
        f_wr_en = 1; f_wr_data = 8'hA5;
        tick();
        f_wr_en = 0;
        check("fwft_ft_data", 32'(f_rd_data), 32'hA5);
        check("fwft_ft_empty", 32'(f_empty), 0);
        check("fwft_ft_valid", 32'(f_valid), 1);
        check("fwft_ft_level", 32'(f_level), 1);
        f_rd_en = 1;
        tick();
        f_rd_en = 0;
        check("fwft_pop_empty", 32'(f_empty), 1);
        check("fwft_pop_valid", 32'(f_valid), 0);
        check("fwft_pop_level", 32'(f_level), 0);

        // Standard: fill across the pointer wrap, overflow, drain
        for (int i = 0; i < 8; i++) begin
            s_wr_en = 1; s_wr_data = 8'h20 + 8'(i);
            tick();
        end
        check("std_fill_full", 32'(s_full), 1);
        check("std_fill_afull", 32'(s_afull), 1);
        check("std_fill_ovf0", 32'(s_ovf), 0);
        s_wr_data = 8'hFF;
        tick();
        s_wr_en = 0;
        check("std_ovf", 32'(s_ovf), 1);
        check("std_ovf_level", 32'(s_level), 8);
        for (int i = 0; i < 8; i++) begin
            s_rd_en = 1;
            tick();
            check("std_drain_data", 32'(s_rd_data), 32'h20 + i);
            if (i == 0) check("std_drain_notfull", 32'(s_full), 0);
        end
        s_rd_en = 0;
        check("std_drain_empty", 32'(s_empty), 1);

        // FWFT: fill, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            f_wr_en = 1; f_wr_data = 8'h30 + 8'(i);
            tick();
        end
        check("fwft_fill_full", 32'(f_full), 1);
        f_wr_data = 8'hEE;
        tick();
        f_wr_en = 0;
        check("fwft_ovf", 32'(f_ovf), 1);
        check("fwft_ovf_level", 32'(f_level), 8);
        for (int i = 0; i < 8; i++) begin
            check("fwft_drain_data", 32'(f_rd_data), 32'h30 + i);
            f_rd_en = 1;
            tick();
        end
        f_rd_en = 0;
        check("fwft_drain_empty", 32'(f_empty), 1);

        // Standard: simultaneous read/write at level 5 for 100 cycles
        for (int i = 0; i < 5; i++) begin
            s_wr_en = 1; s_wr_data = 8'h40 + 8'(i);
            tick();
        end
        exp_rd = 8'h40;
        nxt_wr = 8'h45;
        for (int i = 0; i < 100; i++) begin
            s_wr_en = 1; s_rd_en = 1; s_wr_data = nxt_wr;
            tick();
            nxt_wr = nxt_wr + 8'd1;
            check("std_rw_data", 32'(s_rd_data), 32'(exp_rd));
            check("std_rw_level", 32'(s_level), 5);
            exp_rd = exp_rd + 8'd1;
        end
        s_wr_en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("std_rw_tail", 32'(s_rd_data), 32'(exp_rd));
            exp_rd = exp_rd + 8'd1;
        end
        s_rd_en = 0;
        check("std_rw_empty", 32'(s_empty), 1);

        // FWFT: simultaneous push/pop at level 5
        for (int i = 0; i < 5; i++) begin
            f_wr_en = 1; f_wr_data = 8'h50 + 8'(i);
            tick();
        end
        exp_rd = 8'h50;
        nxt_wr = 8'h55;
        for (int i = 0; i < 20; i++) begin
            check("fwft_rw_data", 32'(f_rd_data), 32'(exp_rd));
            f_wr_en = 1; f_rd_en = 1; f_wr_data = nxt_wr;
            tick();
            nxt_wr = nxt_wr + 8'd1;
            exp_rd = exp_rd + 8'd1;
            check("fwft_rw_level", 32'(f_level), 5);
        end
        f_wr_en = 0; f_rd_en = 0;
        check("fwft_rw_head", 32'(f_rd_data), 32'h64);

        // Standard: underflow, then flush with a write in the flush cycle
        s_rd_en = 1;
        tick();
        s_rd_en = 0;
        check("std_udf", 32'(s_udf), 1);
        check("std_udf_valid", 32'(s_valid), 0);
        check("std_udf_data_hold", 32'(s_rd_data), 32'hA8);
        s_flush = 1; s_wr_en = 1; s_wr_data = 8'h99;
        tick();
        s_flush = 0; s_wr_en = 0;
        check("std_flush_udf", 32'(s_udf), 0);
        check("std_flush_ovf", 32'(s_ovf), 0);
        check("std_flush_level", 32'(s_level), 0);
        check("std_flush_empty", 32'(s_empty), 1);
        check("std_flush_aempty", 32'(s_aempty), 1);
        check("std_flush_full", 32'(s_full), 0);
        check("std_flush_data_hold", 32'(s_rd_data), 32'hA8);

        // Standard: async reset at level 7 mid-burst
        for (int i = 0; i < 7; i++) begin
            s_wr_en = 1; s_wr_data = 8'h60 + 8'(i);
            tick();
        end
        check("std_l7_level", 32'(s_level), 7);
        check("std_l7_afull", 32'(s_afull), 1);
        s_wr_data = 8'h67;
        #2 rst_n = 1'b0;
        #1;
        check("std_arst_level", 32'(s_level), 0);
        check("std_arst_empty", 32'(s_empty), 1);
        check("std_arst_afull", 32'(s_afull), 0);
        check("std_arst_data", 32'(s_rd_data), 0);
        check("fwft_arst_level", 32'(f_level), 0);
        check("fwft_arst_data", 32'(f_rd_data), 0);
        s_wr_en = 0;
        #2 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            s_wr_en = 1; s_wr_data = 8'h70 + 8'(i);
            tick();
        end
        s_wr_en = 0;
        check("std_post_level", 32'(s_level), 2);
        for (int i = 0; i < 2; i++) begin
            s_rd_en = 1;
            tick();
            check("std_post_data", 32'(s_rd_data), 32'h70 + i);
        end
        s_rd_en = 0;
        check("std_post_empty", 32'(s_empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
